// File: rtl/watch_sw_ctrl.sv
// Central watch/stopwatch control FSM: arbitrates debounced button pulses and drives the
// stopwatch run/clear and watch time-set controls. Define WATCH_SW_CTRL_LAP_EN for lap freeze.
module watch_sw_ctrl #(
    parameter int unsigned SET_TIMEOUT = 5000,
    parameter int unsigned CLR_HOLD    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_btn_mode,
    output logic       o_mode,
    output logic       o_sw_run,
    output logic       o_sw_clear,
    output logic [1:0] o_set_field,
    output logic       o_set_inc
`ifdef WATCH_SW_CTRL_LAP_EN
    ,
    output logic       o_lap_freeze
`endif
);

    localparam int unsigned TmoW = $clog2(SET_TIMEOUT + 1);
    localparam int unsigned ClrW = $clog2(CLR_HOLD + 1);

    typedef enum logic [2:0] {
        StWNorm,
        StWSet,
        StSwIdle,
        StSwRun,
        StSwStop
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        field_q, field_d;
    logic              inc_q, inc_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [ClrW-1:0]   clr_cnt_q, clr_cnt_d;
`ifdef WATCH_SW_CTRL_LAP_EN
    logic              lap_q, lap_d;
`endif

    // Only the highest-priority pulse of a cycle is acted on; the rest are dropped.
    logic press_mode, press_clear, press_run;
    assign press_mode  = i_btn_mode;
    assign press_clear = i_btn_clear & ~i_btn_mode;
    assign press_run   = i_btn_run & ~i_btn_clear & ~i_btn_mode;

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        inc_d     = 1'b0;
        tmo_d     = '0;
        clr_cnt_d = (clr_cnt_q != '0) ? clr_cnt_q - ClrW'(1) : '0;
`ifdef WATCH_SW_CTRL_LAP_EN
        lap_d     = lap_q;
`endif
        unique case (state_q)
            StWNorm: begin
                if (press_mode) begin
                    state_d = StSwIdle;
                end else if (press_run) begin
                    state_d = StWSet;
                    field_d = 2'd1;
                end
            end
            StWSet: begin
                if (press_mode) begin
                    state_d = StWNorm;
                    field_d = 2'd0;
                end else if (press_clear) begin
                    inc_d = 1'b1;
                end else if (press_run) begin
                    field_d = (field_q == 2'd3) ? 2'd1 : field_q + 2'd1;
                end else if (i_tick) begin
                    // Exits on the tick that completes the count, so the counter never wraps.
                    if (tmo_q >= TmoW'(SET_TIMEOUT - 1)) begin
                        state_d = StWNorm;
                        field_d = 2'd0;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end else begin
                    tmo_d = tmo_q;
                end
            end
            StSwIdle: begin
                if (press_mode) begin
                    state_d = StWNorm;
                end else if (press_clear) begin
                    clr_cnt_d = ClrW'(CLR_HOLD);
                end else if (press_run) begin
                    // Clear must never overlap a running counter.
                    state_d   = StSwRun;
                    clr_cnt_d = '0;
                end
            end
            StSwRun: begin
                if (press_mode) begin
                    state_d = StWNorm;
`ifdef WATCH_SW_CTRL_LAP_EN
                end else if (press_clear) begin
                    lap_d = ~lap_q;
`endif
                end else if (press_run) begin
                    state_d = StSwStop;
                end
            end
            StSwStop: begin
                if (press_mode) begin
                    state_d = StWNorm;
                end else if (press_clear) begin
                    state_d   = StSwIdle;
                    clr_cnt_d = ClrW'(CLR_HOLD);
`ifdef WATCH_SW_CTRL_LAP_EN
                    lap_d     = 1'b0;
`endif
                end else if (press_run) begin
                    state_d = StSwRun;
                end
            end
            default: begin
                state_d = StWNorm;
                field_d = 2'd0;
            end
        endcase
`ifdef WATCH_SW_CTRL_LAP_EN
        if (state_d == StWNorm) begin
            lap_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StWNorm;
            field_q   <= 2'd0;
            inc_q     <= 1'b0;
            tmo_q     <= '0;
            clr_cnt_q <= '0;
`ifdef WATCH_SW_CTRL_LAP_EN
            lap_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            inc_q     <= inc_d;
            tmo_q     <= tmo_d;
            clr_cnt_q <= clr_cnt_d;
`ifdef WATCH_SW_CTRL_LAP_EN
            lap_q     <= lap_d;
`endif
        end
    end

    assign o_mode      = (state_q == StSwIdle) || (state_q == StSwRun) || (state_q == StSwStop);
    assign o_sw_run    = (state_q == StSwRun);
    assign o_sw_clear  = (clr_cnt_q != '0);
    assign o_set_field = field_q;
    assign o_set_inc   = inc_q;
`ifdef WATCH_SW_CTRL_LAP_EN
    assign o_lap_freeze = lap_q;
`endif

endmodule

// File: tb/tb_watch_sw_ctrl.sv
// Scoreboard bench for watch_sw_ctrl: a behavioural model predicts outputs per cycle,
// a separate monitor compares them. Honours WATCH_SW_CTRL_LAP_EN.
module tb_watch_sw_ctrl;

    localparam int unsigned SetTimeout = 5000;
    localparam int unsigned ClrHold    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic       i_btn_mode = 1'b0;
    logic       o_mode, o_sw_run, o_sw_clear, o_set_inc;
    logic [1:0] o_set_field;
`ifdef WATCH_SW_CTRL_LAP_EN
    logic       o_lap_freeze;
`endif

    watch_sw_ctrl #(
        .SET_TIMEOUT(SetTimeout),
        .CLR_HOLD   (ClrHold)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .i_btn_mode  (i_btn_mode),
        .o_mode      (o_mode),
        .o_sw_run    (o_sw_run),
        .o_sw_clear  (o_sw_clear),
        .o_set_field (o_set_field),
        .o_set_inc   (o_set_inc)
`ifdef WATCH_SW_CTRL_LAP_EN
        ,
        .o_lap_freeze(o_lap_freeze)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mode;
        bit run;
        bit clr;
        int field;
        bit inc;
        bit lap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: watch vs stopwatch, running flag, "has a stopped value" flag,
    // set field (0 = not setting), ticks since last press, clear cycles remaining.
    bit m_sw, m_run, m_stop, m_inc, m_lap;
    int m_field, m_tmo, m_clr;

    function automatic void check(string name, int act, int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
        end
    endfunction

    function automatic void model_reset();
        m_sw = 0; m_run = 0; m_stop = 0; m_inc = 0; m_lap = 0;
        m_field = 0; m_tmo = 0; m_clr = 0;
    endfunction

    function automatic void model_step(bit m, bit c, bit r, bit t);
        int press;
        press = m ? 3 : (c ? 2 : (r ? 1 : 0));
        m_inc = 0;
        if (m_clr > 0) m_clr--;
        if (!m_sw) begin
            if (m_field == 0) begin
                if (press == 3) begin
                    m_sw = 1; m_run = 0; m_stop = 0;
                end else if (press == 1) begin
                    m_field = 1; m_tmo = 0;
                end
            end else begin
                if (press != 0) m_tmo = 0;
                else if (t) m_tmo++;
                case (press)
                    3: m_field = 0;
                    2: m_inc = 1;
                    1: m_field = m_field % 3 + 1;
                    default: ;
                endcase
                if (m_tmo >= SetTimeout) begin
                    m_field = 0; m_tmo = 0;
                end
            end
        end else begin
            if (press == 3) begin
                m_sw = 0; m_run = 0; m_stop = 0; m_lap = 0;
            end else if (m_run) begin
                if (press == 1) begin
                    m_run = 0; m_stop = 1;
                end
`ifdef WATCH_SW_CTRL_LAP_EN
                else if (press == 2) m_lap = !m_lap;
`endif
            end else if (press == 1) begin
                m_run = 1; m_stop = 0;
            end else if (press == 2) begin
                m_clr = ClrHold; m_stop = 0; m_lap = 0;
            end
        end
        if (m_run) m_clr = 0;
    endfunction

    task automatic apply(bit m, bit c, bit r, bit t);
        exp_t e;
        i_btn_mode  = m;
        i_btn_clear = c;
        i_btn_run   = r;
        i_tick      = t;
        model_step(m, c, r, t);
        e.mode = m_sw; e.run = m_run; e.clr = (m_clr > 0); e.field = m_field;
        e.inc = m_inc; e.lap = m_lap;
        exp_q.push_back(e);
    endtask

    task automatic drive(bit m, bit c, bit r, bit t);
        @(negedge clk);
        apply(m, c, r, t);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_btn_mode = 0; i_btn_clear = 0; i_btn_run = 0; i_tick = 0;
        #1;
        check("rst_mode", o_mode, 0);
        check("rst_sw_run", o_sw_run, 0);
        check("rst_sw_clear", o_sw_clear, 0);
        check("rst_set_field", o_set_field, 0);
        check("rst_set_inc", o_set_inc, 0);
`ifdef WATCH_SW_CTRL_LAP_EN
        check("rst_lap", o_lap_freeze, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        apply(0, 0, 0, 0);
    endtask

    // Monitor: every clocked cycle with a pending prediction is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mode", o_mode, e.mode);
            check("sw_run", o_sw_run, e.run);
            check("sw_clear", o_sw_clear, e.clr);
            check("set_field", o_set_field, e.field);
            check("set_inc", o_set_inc, e.inc);
`ifdef WATCH_SW_CTRL_LAP_EN
            check("lap_freeze", o_lap_freeze, e.lap);
`endif
        end
    end

    initial begin
        model_reset();
        do_reset();
        idle(100);

        // Stopwatch: mode, run, run, clear spaced ten cycles apart.
        drive(1, 0, 0, 0); idle(9);
        drive(0, 0, 1, 0); idle(9);
        drive(0, 0, 1, 0); idle(9);
        drive(0, 1, 0, 0); idle(9);
        drive(1, 0, 0, 0); idle(3);

        // Set mode: field 1,2,3,1 then one increment.
        drive(0, 0, 1, 0); idle(2);
        repeat (3) begin
            drive(0, 0, 1, 0); idle(2);
        end
        drive(0, 1, 0, 0); idle(2);

        // Timeout boundary: 4999 ticks stay in set mode, the 5000th exits.
        repeat (SetTimeout - 1) drive(0, 0, 0, 1);
        idle(3);
        drive(0, 0, 0, 1);
        idle(3);

        // Press and tick together: press wins, counter restarts.
        drive(0, 0, 1, 0);
        repeat (SetTimeout - 2) drive(0, 0, 0, 1);
        drive(0, 0, 1, 1);
        repeat (SetTimeout - 1) drive(0, 0, 0, 1);
        idle(2);
        drive(0, 0, 0, 1);
        idle(2);

        // Simultaneous presses in SW_STOP: mode alone is taken.
        drive(1, 0, 0, 0); idle(2);
        drive(0, 0, 1, 0); idle(2);
        drive(0, 0, 1, 0); idle(2);
        drive(1, 1, 1, 0); idle(5);

        // Clear in SW_RUN (lap toggle when enabled, otherwise no effect).
        drive(1, 0, 0, 0); idle(2);
        drive(0, 0, 1, 0); idle(2);
        drive(0, 1, 0, 0); idle(3);
        drive(0, 1, 0, 0); idle(3);
        drive(0, 1, 0, 0); idle(2);
        drive(0, 0, 1, 0); idle(2);
        drive(0, 1, 0, 0); idle(4);

        // Restarted clear hold, then run during hold, then reset mid-hold.
        drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        drive(0, 1, 0, 0); drive(0, 0, 1, 0); idle(3);
        drive(0, 0, 1, 0); drive(0, 1, 0, 0); idle(2);
        drive(0, 1, 0, 0);
        do_reset();
        idle(5);

        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
            end
        end
        idle(5);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/watch_sw_ctrl.md
Name: watch_sw_ctrl

Overview:
- Central control FSM for the watch/stopwatch design.
- Consumes the single-cycle press pulses produced by the per-button debouncers (run, clear, mode).
- Arbitrates simultaneous presses and drives the stopwatch counter, clear, watch time-set field select and increment controls.
- Sits between the debouncers and the time-counter/display datapath.

Parameters:
- SET_TIMEOUT, 5000, number of i_tick pulses without a press before watch set-mode auto-exits to normal watch display (5 s at 1 kHz tick).
- CLR_HOLD, 2, number of clk cycles o_sw_clear is held high when a clear is issued.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- i_tick  input  1  one-cycle 1 kHz timebase strobe
- i_btn_run  input  1  debounced rising-edge pulse, run/stop button
- i_btn_clear  input  1  debounced rising-edge pulse, clear button
- i_btn_mode  input  1  debounced rising-edge pulse, mode button
- o_mode  output  1  0 = watch, 1 = stopwatch
- o_sw_run  output  1  stopwatch counter enable (level)
- o_sw_clear  output  1  stopwatch counter synchronous clear, CLR_HOLD cycles
- o_set_field  output  2  watch set field: 0 none, 1 hour, 2 min, 3 sec
- o_set_inc  output  1  one-cycle increment strobe to the selected watch field
- o_lap_freeze  output  1  display freeze; present only with WATCH_SW_CTRL_LAP_EN (otherwise absent)

Behaviour:
- Reset (rst=0, async): state W_NORM; all outputs 0; timeout counter 0; clear-hold counter 0.
- Press arbitration: if more than one pulse arrives in the same cycle, only one is acted on, with priority mode > clear > run. Lower-priority pulses in that cycle are discarded, not queued.
- States and transitions (pulses are sampled on posedge clk; outputs are registered, so the effect appears 1 cycle after the pulse):
  - W_NORM (o_mode=0, o_set_field=0):
    - mode -> SW_IDLE
    - run -> W_SET with o_set_field=1
    - clear ignored
  - W_SET (o_mode=0):
    - run advances o_set_field 1->2->3->1 (wraps)
    - clear emits o_set_inc=1 for 1 cycle
    - mode -> W_NORM, o_set_field=0
    - timeout counter increments on i_tick and resets to 0 on any accepted press. On reaching SET_TIMEOUT -> W_NORM, o_set_field=0.
  - SW_IDLE (o_mode=1, o_sw_run=0):
    - run -> SW_RUN
    - clear issues a clear pulse
    - mode -> W_NORM
  - SW_RUN (o_mode=1, o_sw_run=1):
    - run -> SW_STOP
    - mode -> W_NORM with o_sw_run=0; the stopwatch value is retained
    - clear ignored (see optional feature)
  - SW_STOP (o_mode=1, o_sw_run=0):
    - run -> SW_RUN
    - clear -> SW_IDLE and issues a clear pulse
    - mode -> W_NORM
- Clear pulse: o_sw_clear is high for exactly CLR_HOLD consecutive cycles, starting 1 cycle after the accepted press. A new clear arriving during the hold restarts the hold count.
- o_set_inc is never asserted outside W_SET. o_sw_clear is never asserted while o_sw_run=1.
- i_tick arriving in the same cycle as an accepted press: the press wins and the timeout counter goes to 0.
- Timeout counter width is $clog2(SET_TIMEOUT+1). It saturates and never wraps.
- Reset mid-operation (including mid clear-hold or mid set-mode) immediately forces the reset values above.

Optional Feature:
- Macro: WATCH_SW_CTRL_LAP_EN.
- Defined:
  - o_lap_freeze exists and resets to 0.
  - In SW_RUN, clear toggles o_lap_freeze and o_sw_run stays 1.
  - Leaving SW_RUN via mode forces o_lap_freeze=0.
  - Entering SW_STOP keeps the current o_lap_freeze value.
  - Clear in SW_STOP (transition to SW_IDLE) forces o_lap_freeze=0.
- Not defined: port absent; clear in SW_RUN has no effect.

Test Plan:
- Reset release, no presses -> o_mode=0, o_sw_run=0, o_sw_clear=0, o_set_field=0, o_set_inc=0 held for 100 cycles.
- mode, run, run, clear pulses spaced 10 cycles apart:
  - o_mode=1 after the mode pulse
  - o_sw_run=1, then o_sw_run=0
  - o_sw_clear high for exactly 2 cycles, starting 1 cycle after the clear pulse
  - final state SW_IDLE
- From W_NORM: run, then run x3, then clear -> o_set_field sequence 1,2,3,1; one o_set_inc pulse while o_set_field=1.
- In W_SET with SET_TIMEOUT=5000: 4999 i_tick pulses with no press -> still W_SET. The 5000th tick -> o_set_field=0 the next cycle.
- In SW_STOP: mode, clear and run all pulsed in the same cycle -> only mode is taken: o_mode=0, no o_sw_clear, o_sw_run=0.
- With WATCH_SW_CTRL_LAP_EN, in SW_RUN: clear, clear -> o_lap_freeze 1 then 0, o_sw_run stays 1. Assert rst=0 mid-clear-hold -> all outputs 0 immediately.
